// File: rtl/screen_arbiter_pkg.sv
// Shared types and constants for the screen rectangle-fill arbiter.
package screen_arb_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_COLOUR_WIDTH = 3;
  localparam int DEF_N_REQ        = 4;
  localparam int SCREEN_W         = 160;
  localparam int SCREEN_H         = 120;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/screen_arbiter_rr_pick.sv
// Round-robin picker: the first asserted request scanning upward from ptr, wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int w_j;

  // Scan from the far end back toward ptr so the nearest hit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j = (int'(ptr) + k) % N_REQ;
      if (req[w_j]) begin
        valid = 1'b1;
        idx   = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/screen_arbiter.sv
// Shares one rectangle-fill screen interface between N_REQ draw modules, round-robin.
module screen_arbiter
  import screen_arb_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
  parameter int N_REQ        = DEF_N_REQ,
  parameter int IDX_W        = $clog2(N_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_start,
  input  logic [N_REQ*COLOUR_WIDTH-1:0] req_colour,
  input  logic [N_REQ*WIDTH-1:0]    req_x_min,
  input  logic [N_REQ*WIDTH-1:0]    req_y_min,
  input  logic [N_REQ*WIDTH-1:0]    req_x_range,
  input  logic [N_REQ*WIDTH-1:0]    req_y_range,
  output logic [N_REQ-1:0]          req_grant,
  output logic [N_REQ-1:0]          req_done,
  output logic [WIDTH-1:0]          req_screen_x,
  output logic [WIDTH-1:0]          req_screen_y,
  output logic [COLOUR_WIDTH-1:0]   req_old_colour,
  output logic                      screen_start,
  output logic [COLOUR_WIDTH-1:0]   new_screen_colour,
  output logic [WIDTH-1:0]          screen_x_min,
  output logic [WIDTH-1:0]          screen_y_min,
  output logic [WIDTH-1:0]          screen_x_range,
  output logic [WIDTH-1:0]          screen_y_range,
  input  logic [WIDTH-1:0]          screen_x,
  input  logic [WIDTH-1:0]          screen_y,
  input  logic [COLOUR_WIDTH-1:0]   old_screen_colour,
  input  logic                      screen_done,
  output logic [1:0]                o_dbg_state
);

  // Handshake: a requester raises req_start and holds it with its job fields stable until
  // it sees its req_done pulse; the job is copied at grant, so later field changes are ignored.

  state_t                  r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [N_REQ-1:0]        r_grant;
  logic                    r_screen_start;
  logic [COLOUR_WIDTH-1:0] r_colour;
  logic [WIDTH-1:0]        r_x_min;
  logic [WIDTH-1:0]        r_y_min;
  logic [WIDTH-1:0]        r_x_range;
  logic [WIDTH-1:0]        r_y_range;

  logic                    w_valid;
  logic [IDX_W-1:0]        w_idx;
  logic [N_REQ-1:0]        w_one;

  assign w_one = {{(N_REQ-1){1'b0}}, 1'b1};

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_start),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_grant        <= '0;
      r_screen_start <= 1'b0;
      r_colour       <= '0;
      r_x_min        <= '0;
      r_y_min        <= '0;
      r_x_range      <= '0;
      r_y_range      <= '0;
    end else begin
      r_screen_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_grant        <= w_one << w_idx;
            r_colour       <= req_colour[w_idx*COLOUR_WIDTH +: COLOUR_WIDTH];
            r_x_min        <= req_x_min[w_idx*WIDTH +: WIDTH];
            r_y_min        <= req_y_min[w_idx*WIDTH +: WIDTH];
            r_x_range      <= req_x_range[w_idx*WIDTH +: WIDTH];
            r_y_range      <= req_y_range[w_idx*WIDTH +: WIDTH];
            r_ptr          <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_screen_start <= 1'b1;
            r_state        <= S_START;
          end
        end
        S_START: r_state <= S_BUSY;
        S_BUSY: begin
          if (screen_done) begin
            r_grant <= '0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign req_grant         = r_grant;
  assign req_done          = (r_state == S_BUSY && screen_done) ? r_grant : '0;
  assign screen_start      = r_screen_start;
  assign new_screen_colour = r_colour;
  assign screen_x_min      = r_x_min;
  assign screen_y_min      = r_y_min;
  assign screen_x_range    = r_x_range;
  assign screen_y_range    = r_y_range;
  assign req_screen_x      = screen_x;
  assign req_screen_y      = screen_y;
  assign req_old_colour    = old_screen_colour;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter: cycle table for one-owner jobs plus hand sequences.
module tb_screen_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_start;
  logic [11:0] req_colour;
  logic [31:0] req_x_min, req_y_min, req_x_range, req_y_range;
  logic [3:0]  req_grant, req_done;
  logic [7:0]  req_screen_x, req_screen_y;
  logic [2:0]  req_old_colour;
  logic        screen_start;
  logic [2:0]  new_screen_colour;
  logic [7:0]  screen_x_min, screen_y_min, screen_x_range, screen_y_range;
  logic [7:0]  screen_x, screen_y;
  logic [2:0]  old_screen_colour;
  logic        screen_done;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  screen_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .req_start         (req_start),
    .req_colour        (req_colour),
    .req_x_min         (req_x_min),
    .req_y_min         (req_y_min),
    .req_x_range       (req_x_range),
    .req_y_range       (req_y_range),
    .req_grant         (req_grant),
    .req_done          (req_done),
    .req_screen_x      (req_screen_x),
    .req_screen_y      (req_screen_y),
    .req_old_colour    (req_old_colour),
    .screen_start      (screen_start),
    .new_screen_colour (new_screen_colour),
    .screen_x_min      (screen_x_min),
    .screen_y_min      (screen_y_min),
    .screen_x_range    (screen_x_range),
    .screen_y_range    (screen_y_range),
    .screen_x          (screen_x),
    .screen_y          (screen_y),
    .old_screen_colour (old_screen_colour),
    .screen_done       (screen_done),
    .o_dbg_state       (o_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] start;
    logic       done;
    logic [3:0] grant;
    logic [3:0] rdone;
    logic       sstart;
    logic [1:0] state;
    logic [2:0] colour;
    logic [7:0] xmin;
  } vec_t;

  vec_t tbl [14];
  int   rr_exp [6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input int budget, output int cycles);
    cycles = 0;
    while (req_grant == 4'b0000 && cycles < budget) begin
      tick();
      cycles++;
    end
    if (req_grant == 4'b0000) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_job_zero(input string name);
    chk({name, "_colour"}, 32'(new_screen_colour), 32'd0);
    chk({name, "_xmin"},   32'(screen_x_min), 32'd0);
    chk({name, "_ymin"},   32'(screen_y_min), 32'd0);
    chk({name, "_xrange"}, 32'(screen_x_range), 32'd0);
    chk({name, "_yrange"}, 32'(screen_y_range), 32'd0);
  endtask

  initial begin
    int c;
    logic [7:0] bx, by;
    logic [2:0] bc;

    // cycle table: inputs for the cycle, outputs expected in that same cycle
    tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 3'd0, 8'd0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd1, 3'd5, 8'd10};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, 3'd5, 8'd10};
    tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd2, 3'd5, 8'd10};
    tbl[4]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 3'd5, 8'd10};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 3'd5, 8'd10};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 3'd5, 8'd10};
    tbl[7]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 3'd5, 8'd10};
    tbl[8]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 2'd1, 3'd1, 8'd10};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd2, 3'd1, 8'd10};
    tbl[10] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd2, 3'd1, 8'd10};
    tbl[11] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd2, 3'd1, 8'd10};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 3'd1, 8'd10};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 3'd1, 8'd10};
    rr_exp = '{0, 1, 3, 0, 1, 3};

    // driver defaults: per-requester jobs, slice i belongs to requester i
    reset             = 1'b1;
    req_start         = 4'b0000;
    req_colour        = {3'd7, 3'd5, 3'd2, 3'd1};
    req_x_min         = {8'd70, 8'd10, 8'd50, 8'd10};
    req_y_min         = {8'd71, 8'd20, 8'd51, 8'd11};
    req_x_range       = {8'd72, 8'd30, 8'd52, 8'd12};
    req_y_range       = {8'd73, 8'd40, 8'd53, 8'd13};
    screen_x          = 8'd0;
    screen_y          = 8'd0;
    old_screen_colour = 3'd0;
    screen_done       = 1'b0;

    // reset values
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_start", 32'(screen_start), 32'd0);
    chk_job_zero("rst");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_grant", 32'(req_grant), 32'd0);
      chk("idle_start", 32'(screen_start), 32'd0);
    end

    // single request, ignored done in IDLE and START
    for (int i = 0; i < 14; i++) begin
      req_start         = tbl[i].start;
      screen_done       = tbl[i].done;
      bx                = 8'($urandom_range(0, 159));
      by                = 8'($urandom_range(0, 119));
      bc                = 3'($urandom_range(0, 7));
      screen_x          = bx;
      screen_y          = by;
      old_screen_colour = bc;
      #2;
      chk($sformatf("tbl%0d_grant", i),  32'(req_grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_done", i),   32'(req_done), 32'(tbl[i].rdone));
      chk($sformatf("tbl%0d_sstart", i), 32'(screen_start), 32'(tbl[i].sstart));
      chk($sformatf("tbl%0d_state", i),  32'(o_dbg_state), 32'(tbl[i].state));
      chk($sformatf("tbl%0d_colour", i), 32'(new_screen_colour), 32'(tbl[i].colour));
      chk($sformatf("tbl%0d_xmin", i),   32'(screen_x_min), 32'(tbl[i].xmin));
      chk($sformatf("tbl%0d_bx", i),     32'(req_screen_x), 32'(bx));
      chk($sformatf("tbl%0d_by", i),     32'(req_screen_y), 32'(by));
      chk($sformatf("tbl%0d_bc", i),     32'(req_old_colour), 32'(bc));
      if (i == 1) begin
        chk("job2_ymin", 32'(screen_y_min), 32'd20);
        chk("job2_xrange", 32'(screen_x_range), 32'd30);
        chk("job2_yrange", 32'(screen_y_range), 32'd40);
      end
      tick();
    end
    screen_done = 1'b0;

    // round-robin from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_start = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      wait_grant(10, c);
      if (j > 0) chk($sformatf("rr%0d_latency", j), 32'(c), 32'd2);
      chk($sformatf("rr%0d_grant", j), 32'(req_grant), 32'(4'b0001 << rr_exp[j]));
      chk($sformatf("rr%0d_sstart", j), 32'(screen_start), 32'd1);
      repeat (5) tick();
      screen_done = 1'b1;
      #1;
      chk($sformatf("rr%0d_done", j), 32'(req_done), 32'(4'b0001 << rr_exp[j]));
      tick();
      screen_done = 1'b0;
      chk($sformatf("rr%0d_release", j), 32'(req_grant), 32'd0);
      chk($sformatf("rr%0d_relstate", j), 32'(o_dbg_state), 32'd3);
    end

    // latched job: requester 0 changes x_min while granted
    req_start = 4'b0001;
    wait_grant(10, c);
    chk("latch_grant", 32'(req_grant), 32'd1);
    chk("latch_xmin0", 32'(screen_x_min), 32'd10);
    req_x_min[7:0] = 8'd99;
    repeat (3) tick();
    chk("latch_xmin1", 32'(screen_x_min), 32'd10);
    screen_done = 1'b1;
    tick();
    screen_done = 1'b0;
    req_start = 4'b0000;
    chk("latch_xmin2", 32'(screen_x_min), 32'd10);
    tick();
    chk("latch_xmin3", 32'(screen_x_min), 32'd10);
    req_x_min[7:0] = 8'd10;

    // reset mid-job: pointer must return to 0
    req_start = 4'b0010;
    wait_grant(10, c);
    chk("mid_grant", 32'(req_grant), 32'd2);
    tick();
    chk("mid_busy", 32'(o_dbg_state), 32'd2);
    req_start = 4'b1010;
    reset = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(req_grant), 32'd0);
    chk("mid_rst_state", 32'(o_dbg_state), 32'd0);
    chk("mid_rst_done", 32'(req_done), 32'd0);
    chk_job_zero("mid_rst");
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 32'(req_grant), 32'd2);
    chk("post_rst_sstart", 32'(screen_start), 32'd1);
    chk("post_rst_colour", 32'(new_screen_colour), 32'd2);
    tick();
    req_start = 4'b0000;
    screen_done = 1'b1;
    #1;
    chk("post_rst_done", 32'(req_done), 32'd2);
    tick();
    screen_done = 1'b0;
    tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
